// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared constants for the cache miss-handling controller
package cache_pkg;

  localparam int DEF_A_WIDTH = 8;
  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_N       = 4;
  localparam int DEF_RAM_LAT = 2;
  localparam int AGE_W       = $clog2(DEF_N);

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOOKUP = 3'd1;
  localparam state_t ST_WBACK  = 3'd2;
  localparam state_t ST_FILL   = 3'd3;
  localparam state_t ST_RESP   = 3'd4;

endpackage

// File: rtl/lru_tracker.sv
// rtl/lru_tracker.sv - LRU age permutation and victim choice (invalid first, else age 0)
module lru_tracker
  import cache_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [N-1:0]     valid_mask,
  output logic [IDX_W-1:0] victim
);

  logic [IDX_W-1:0] age_q [N];
  logic [IDX_W-1:0] age_d [N];

  always_comb begin
    age_d = age_q;
    if (touch_en) begin
      for (int k = 0; k < N; k++) begin
        if (age_q[k] > age_q[touch_idx]) age_d[k] = age_q[k] - 1'b1;
      end
      age_d[touch_idx] = IDX_W'(N - 1);
    end
  end

  // Descending scan so the lowest-index invalid entry wins over the age-0 entry.
  always_comb begin
    victim = '0;
    for (int i = 0; i < N; i++) begin
      if (age_q[i] == '0) victim = IDX_W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_mask[i]) victim = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < N; i++) age_q[i] <= IDX_W'(i);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - fully associative write-back cache: lookup, victim write-back, fill
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int N       = DEF_N,
  parameter int RAM_LAT = DEF_RAM_LAT
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req,
  input  logic               rw,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] wdata,
  output logic [D_WIDTH-1:0] rdata,
  output logic               done,
  output logic               hit,
  output logic               busy,
  output logic               ram_enab,
  output logic               ram_rw,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic [D_WIDTH-1:0] ram_wdata,
  input  logic [D_WIDTH-1:0] ram_rdata,
  output logic [N-1:0]       valid_mask
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]   victim_q, victim_d;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;
  logic               hit_q, hit_d;
  logic [A_WIDTH-1:0] tag_q [N];
  logic [A_WIDTH-1:0] tag_d [N];
  logic [D_WIDTH-1:0] data_q [N];
  logic [D_WIDTH-1:0] data_d [N];
  logic [N-1:0]       valid_q, valid_d;
  logic [N-1:0]       dirty_q, dirty_d;

  logic               lookup_hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   lru_victim;
  logic               touch_en;
  logic [IDX_W-1:0]   touch_idx;
  logic               ram_last;

  assign ram_last = (cnt_q == CNT_LAST);

  always_comb begin
    lookup_hit = 1'b0;
    hit_idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == addr_q)) begin
        lookup_hit = 1'b1;
        hit_idx    = IDX_W'(i);
      end
    end
  end

  assign touch_en  = ((state_q == ST_LOOKUP) && lookup_hit) || ((state_q == ST_FILL) && ram_last);
  assign touch_idx = (state_q == ST_LOOKUP) ? hit_idx : victim_q;

  lru_tracker #(.N(N), .IDX_W(IDX_W)) u_lru (
    .clk        (clk),
    .clr        (clr),
    .touch_en   (touch_en),
    .touch_idx  (touch_idx),
    .valid_mask (valid_q),
    .victim     (lru_victim)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    victim_d = victim_q;
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    tag_d    = tag_q;
    data_d   = data_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = addr;
          rw_d    = rw;
          wdata_d = wdata;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit) begin
          if (rw_q == RW_WRITE) begin
            data_d[hit_idx]  = wdata_q;
            dirty_d[hit_idx] = 1'b1;
            rdata_d          = wdata_q;
          end else begin
            rdata_d = data_q[hit_idx];
          end
          hit_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          victim_d = lru_victim;
          cnt_d    = '0;
          state_d  = (valid_q[lru_victim] && dirty_q[lru_victim]) ? ST_WBACK : ST_FILL;
        end
      end
      ST_WBACK: begin
        if (ram_last) begin
          cnt_d   = '0;
          state_d = ST_FILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FILL: begin
        // The line is only installed on the last RAM cycle, so an abort leaves nothing behind.
        if (ram_last) begin
          cnt_d             = '0;
          tag_d[victim_q]   = addr_q;
          valid_d[victim_q] = 1'b1;
          dirty_d[victim_q] = (rw_q == RW_WRITE);
          data_d[victim_q]  = (rw_q == RW_WRITE) ? wdata_q : ram_rdata;
          rdata_d           = (rw_q == RW_WRITE) ? wdata_q : ram_rdata;
          hit_d             = 1'b0;
          state_d           = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= RW_READ;
      wdata_q  <= '0;
      victim_q <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      victim_q <= victim_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
    end
  end

  // RAM strobes decode straight from state so clr kills them without a clock.
  assign done       = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign ram_enab   = (state_q == ST_WBACK) || (state_q == ST_FILL);
  assign ram_rw     = (state_q == ST_WBACK) ? RW_WRITE : RW_READ;
  assign ram_addr   = (state_q == ST_WBACK) ? tag_q[victim_q] :
                      (state_q == ST_FILL)  ? addr_q : '0;
  assign ram_wdata  = (state_q == ST_WBACK) ? data_q[victim_q] : '0;
  assign rdata      = rdata_q;
  assign hit        = hit_q;
  assign valid_mask = valid_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - vector table plus scoreboard bench for cache_ctrl
module tb_cache_ctrl;

  localparam int RAM_LAT = 2;

  typedef struct {
    bit         clr_before;
    bit         rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    bit         hit;
    logic [7:0] rdata;
    bit         wb;
    logic [7:0] wb_addr;
    logic [7:0] wb_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr, req, rw;
  logic [7:0] addr, wdata, rdata, ram_addr, ram_wdata, ram_rdata;
  logic       done, hit, busy, ram_enab, ram_rw;
  logic [3:0] valid_mask;

  int n_vec = 0;
  int n_bad = 0;
  vec_t sb[$];

  always #5 clk = ~clk;

  cache_ctrl #(.A_WIDTH(8), .D_WIDTH(8), .N(4), .RAM_LAT(RAM_LAT)) dut (
    .clk        (clk),
    .clr        (clr),
    .req        (req),
    .rw         (rw),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .done       (done),
    .hit        (hit),
    .busy       (busy),
    .ram_enab   (ram_enab),
    .ram_rw     (ram_rw),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .valid_mask (valid_mask)
  );

  // RAM: unwritten words read as addr^0x5A; data is only driven on the last read cycle.
  logic [7:0] wmem [256];
  bit         wflag [256];
  int         rd_run = 0;

  assign ram_rdata = (ram_enab && !ram_rw && rd_run == RAM_LAT - 1) ?
                     (wflag[ram_addr] ? wmem[ram_addr] : (ram_addr ^ 8'h5A)) : 8'hEE;

  always @(posedge clk) begin
    if (ram_enab && ram_rw) begin
      wmem[ram_addr]  <= ram_wdata;
      wflag[ram_addr] <= 1'b1;
    end
    rd_run <= (ram_enab && !ram_rw) ? rd_run + 1 : 0;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: latency counted from the first busy cycle after acceptance.
  int   lat, rdn, wrn, badram;
  bit   busy_prev;
  vec_t e;

  always @(negedge clk) begin
    if (clr) begin
      busy_prev = 1'b0;
      lat = 0; rdn = 0; wrn = 0; badram = 0;
    end else begin
      if (busy && !busy_prev) begin
        lat = 1; rdn = 0; wrn = 0; badram = 0;
      end else if (busy) begin
        lat++;
      end
      if (ram_enab && sb.size() > 0) begin
        if (!ram_rw) begin
          rdn++;
          if (ram_addr != sb[0].addr) badram++;
        end else begin
          wrn++;
          if (ram_addr != sb[0].wb_addr || ram_wdata != sb[0].wb_data) badram++;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("hit", hit, e.hit);
          if (!e.rw) check("rdata", rdata, e.rdata);
          check("latency", lat, e.hit ? 2 : 2 + RAM_LAT + (e.wb ? RAM_LAT : 0));
          check("ram_rd_cycles", rdn, e.hit ? 0 : RAM_LAT);
          check("ram_wr_cycles", wrn, e.wb ? RAM_LAT : 0);
          check("ram_addr_data", badram, 0);
        end
      end
      busy_prev = busy;
    end
  end

  always @(negedge clk) begin : age_chk
    logic [3:0] seen;
    seen = '0;
    for (int i = 0; i < 4; i++) seen[dut.u_lru.age_q[i]] = 1'b1;
    check("age_perm", seen, 4'hF);
  end

  task automatic do_req(input vec_t v);
    int t;
    if (v.clr_before) begin
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
    end
    @(negedge clk);
    t = 0;
    while (busy && t < 50) begin @(negedge clk); t++; end
    req = 1'b1; rw = v.rw; addr = v.addr; wdata = v.wdata;
    sb.push_back(v);
    @(negedge clk);
    req = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      check("txn_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  vec_t tbl [18];
  vec_t v;
  logic [7:0] exp_tag [4];
  int nd, t;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    //          clr rw addr   wdata  hit rdata  wb wb_addr wb_data
    tbl[0]  = '{1, 0, 8'h00, 8'h00, 0, 8'h5A, 0, 8'h00, 8'h00};
    tbl[1]  = '{0, 0, 8'h00, 8'h00, 1, 8'h5A, 0, 8'h00, 8'h00};
    tbl[2]  = '{1, 0, 8'h10, 8'h00, 0, 8'h4A, 0, 8'h00, 8'h00};
    tbl[3]  = '{0, 0, 8'h20, 8'h00, 0, 8'h7A, 0, 8'h00, 8'h00};
    tbl[4]  = '{0, 0, 8'h30, 8'h00, 0, 8'h6A, 0, 8'h00, 8'h00};
    tbl[5]  = '{0, 0, 8'h40, 8'h00, 0, 8'h1A, 0, 8'h00, 8'h00};
    tbl[6]  = '{0, 0, 8'h10, 8'h00, 1, 8'h4A, 0, 8'h00, 8'h00};
    tbl[7]  = '{0, 0, 8'h50, 8'h00, 0, 8'h0A, 0, 8'h00, 8'h00};
    tbl[8]  = '{1, 1, 8'h11, 8'hA1, 0, 8'h00, 0, 8'h00, 8'h00};
    tbl[9]  = '{0, 1, 8'h12, 8'hA2, 0, 8'h00, 0, 8'h00, 8'h00};
    tbl[10] = '{0, 1, 8'h13, 8'hA3, 0, 8'h00, 0, 8'h00, 8'h00};
    tbl[11] = '{0, 1, 8'h14, 8'hA4, 0, 8'h00, 0, 8'h00, 8'h00};
    tbl[12] = '{0, 0, 8'h15, 8'h00, 0, 8'h4F, 1, 8'h11, 8'hA1};
    tbl[13] = '{0, 0, 8'h11, 8'h00, 0, 8'hA1, 1, 8'h12, 8'hA2};
    tbl[14] = '{0, 1, 8'h13, 8'h77, 1, 8'h00, 0, 8'h00, 8'h00};
    tbl[15] = '{0, 0, 8'h13, 8'h00, 1, 8'h77, 0, 8'h00, 8'h00};
    tbl[16] = '{0, 0, 8'h14, 8'h00, 1, 8'hA4, 0, 8'h00, 8'h00};
    tbl[17] = '{0, 0, 8'h22, 8'h00, 0, 8'h78, 0, 8'h00, 8'h00};
    exp_tag[0] = 8'h10; exp_tag[1] = 8'h50; exp_tag[2] = 8'h30; exp_tag[3] = 8'h40;

    clr = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_done", done, 0);
    check("rst_hit", hit, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_enab", ram_enab, 0);
    check("rst_ram_rw", ram_rw, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_valid_mask", valid_mask, 0);
    for (int i = 0; i < 4; i++) check("rst_age", dut.u_lru.age_q[i], i);
    clr = 1'b0;

    for (int i = 0; i < 18; i++) begin
      do_req(tbl[i]);
      if (i == 7) begin
        check("lru_valid_mask", valid_mask, 4'hF);
        for (int k = 0; k < 4; k++) check("lru_tag", dut.tag_q[k], exp_tag[k]);
      end
      if (i == 12) check("wb_mem", wflag[8'h11] ? wmem[8'h11] : 8'h00, 8'hA1);
    end

    // req held high: each IDLE acceptance yields exactly one done
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    v = '{0, 0, 8'h33, 8'h00, 0, 8'h69, 0, 8'h00, 8'h00};
    sb.push_back(v);
    v.hit = 1'b1;
    sb.push_back(v);
    sb.push_back(v);
    req = 1'b1; rw = 1'b0; addr = 8'h33; wdata = 8'h00;
    nd = 0; t = 0;
    while (nd < 3 && t < 60) begin
      @(negedge clk); t++;
      if (done) nd++;
    end
    req = 1'b0;
    check("hold_done_count", nd, 3);
    repeat (6) @(negedge clk);
    check("hold_sb_empty", sb.size(), 0);
    check("hold_idle", busy, 0);

    // clr in the middle of a fill
    v = '{1, 0, 8'h21, 8'h00, 0, 8'h7B, 0, 8'h00, 8'h00};
    do_req(v);
    @(negedge clk);
    v = '{0, 0, 8'h22, 8'h00, 0, 8'h78, 0, 8'h00, 8'h00};
    sb.push_back(v);
    req = 1'b1; rw = 1'b0; addr = 8'h22;
    @(negedge clk);
    req = 1'b0;
    t = 0;
    while (!ram_enab && t < 20) begin @(negedge clk); t++; end
    check("fill_started", ram_enab, 1);
    clr = 1'b1;
    #1;
    check("clr_ram_enab", ram_enab, 0);
    check("clr_valid_mask", valid_mask, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    sb.delete();
    @(negedge clk);
    clr = 1'b0;
    v = '{0, 0, 8'h21, 8'h00, 0, 8'h7B, 0, 8'h00, 8'h00};
    do_req(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
